// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: phase encodings, opcode map,
// instruction field positions and the opcode classifier.
package instr_pkg;

  // WRITEBACK must stay 3'b100: the register file keys its write on it.
  typedef enum logic [2:0] {
    FETCH     = 3'b000,
    DECODE    = 3'b001,
    EXECUTE   = 3'b010,
    MEMORY    = 3'b011,
    WRITEBACK = 3'b100,
    HALT      = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_HALT
  } op_class_t;

  localparam logic [4:0] OP_HALT  = 5'h0F;
  localparam logic [4:0] OP_LOAD  = 5'h10;
  localparam logic [4:0] OP_STORE = 5'h13;
  localparam logic [4:0] OP_BR_LO = 5'h08;
  localparam logic [4:0] OP_BR_HI = 5'h0E;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int LIT_MSB = 11;
  localparam int LIT_LSB = 0;

  localparam int WAIT_CNT_W = 16;

  function automatic op_class_t op_class(input logic [4:0] opc);
    if (opc == OP_HALT)
      return CLS_HALT;
    else if (opc == OP_LOAD)
      return CLS_LOAD;
    else if (opc == OP_STORE)
      return CLS_STORE;
    else if (opc >= OP_BR_LO && opc <= OP_BR_HI)
      return CLS_BRANCH;
    else
      return CLS_ALU;
  endfunction

endpackage

// File: rtl/instr_sequencer_mem_wait_timer.sv
// Wait counter shared by the fetch and data-memory handshakes; expire_o fires in the
// TIMEOUT_CYCLES-th consecutive not-ready cycle. TIMEOUT_CYCLES=0 disables it.
module mem_wait_timer
  import instr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_active_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  // Ready in the limit cycle suppresses expiry, so a late handshake still completes.
  assign expire_o = (TIMEOUT_CYCLES != 0) && wait_active_i && !ready_i && (cnt_q == LIMIT);

  // Any cycle outside a wait, or a completed handshake, leaves the count at zero,
  // so every entry into FETCH or MEMORY starts from a clean count.
  always_comb begin
    cnt_d = '0;
    if ((TIMEOUT_CYCLES != 0) && wait_active_i && !ready_i && !expire_o)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer feeding the register file: fetch, decode, execute,
// optional data-memory access and a single-cycle writeback per instruction.
module instr_sequencer
  import instr_pkg::*;
#(
  parameter int INSTR_W        = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [2:0]         state,
  output logic [INSTR_W-1:0] instr,
  output logic [4:0]         opcode,
  output logic [11:0]        literal,
  output logic [4:0]         read_reg1,
  output logic [4:0]         read_reg2,
  output logic [4:0]         read_reg3,
  output logic [4:0]         write_reg,
  output logic               write_en,
  output logic               pc_update,
  output logic               halted,
  output logic               fault
);

  state_t             state_q;
  logic [INSTR_W-1:0] instr_q;
  logic               halted_q, fault_q;
  op_class_t          cls;
  logic               wait_active, wait_ready, expire;

  assign opcode    = instr_q[OPC_MSB:OPC_LSB];
  assign literal   = instr_q[LIT_MSB:LIT_LSB];
  assign read_reg1 = instr_q[RS_MSB:RS_LSB];
  assign read_reg2 = instr_q[RT_MSB:RT_LSB];
  assign read_reg3 = instr_q[RD_MSB:RD_LSB];
  assign write_reg = instr_q[RD_MSB:RD_LSB];
  assign cls       = op_class(opcode);

  assign wait_active = (state_q == FETCH) || (state_q == MEMORY);
  assign wait_ready  = (state_q == FETCH) ? imem_ready : dmem_ready;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk          (clk),
    .reset        (reset),
    .wait_active_i(wait_active),
    .ready_i      (wait_ready),
    .expire_o     (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      instr_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state_q <= DECODE;
          end else if (expire) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end
        end
        DECODE: begin
          if (cls == CLS_HALT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= EXECUTE;
          end
        end
        EXECUTE: begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_q <= MEMORY;
            CLS_BRANCH:          state_q <= FETCH;
            default:             state_q <= WRITEBACK;
          endcase
        end
        MEMORY: begin
          if (dmem_ready) begin
            state_q <= (cls == CLS_LOAD) ? WRITEBACK : FETCH;
          end else if (expire) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end
        end
        WRITEBACK: state_q <= FETCH;
        HALT:      state_q <= HALT;
        default:   state_q <= FETCH;
      endcase
    end
  end

  // Strobes decode from the registered state and latched instruction; the store
  // completion pulse also needs dmem_ready so the PC advances on the accept cycle.
  assign state     = state_q;
  assign instr     = instr_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign imem_req  = (state_q == FETCH);
  assign dmem_req  = (state_q == MEMORY);
  assign dmem_we   = (state_q == MEMORY) && (cls == CLS_STORE);
  assign write_en  = (state_q == WRITEBACK);
  assign pc_update = (state_q == WRITEBACK)
                   || ((state_q == EXECUTE) && (cls == CLS_BRANCH))
                   || ((state_q == MEMORY) && (cls == CLS_STORE) && dmem_ready);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one instance with a 4-cycle timeout and one
// with the timeout disabled, both driven by the same stimulus.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, dmem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req, dmem_req, dmem_we, write_en, pc_update, halted, fault;
  logic [2:0]  state;
  logic [31:0] instr;
  logic [4:0]  opcode, read_reg1, read_reg2, read_reg3, write_reg;
  logic [11:0] literal;

  logic        imem_req0, dmem_req0, dmem_we0, write_en0, pc_update0, halted0, fault0;
  logic [2:0]  state0;
  logic [31:0] instr0;
  logic [4:0]  opcode0, read_reg10, read_reg20, read_reg30, write_reg0;
  logic [11:0] literal0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_sequencer #(.INSTR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .state(state), .instr(instr), .opcode(opcode), .literal(literal),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_reg3(read_reg3),
    .write_reg(write_reg), .write_en(write_en), .pc_update(pc_update),
    .halted(halted), .fault(fault)
  );

  instr_sequencer #(.INSTR_W(32), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_ready(dmem_ready), .imem_req(imem_req0), .dmem_req(dmem_req0), .dmem_we(dmem_we0),
    .state(state0), .instr(instr0), .opcode(opcode0), .literal(literal0),
    .read_reg1(read_reg10), .read_reg2(read_reg20), .read_reg3(read_reg30),
    .write_reg(write_reg0), .write_en(write_en0), .pc_update(pc_update0),
    .halted(halted0), .fault(fault0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checks the phase and the two write-side strobes after inputs have settled.
  task automatic expect_ph(input string tag, input logic [2:0] st, input logic we, input logic pcu);
    #1;
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".write_en"}, {31'd0, write_en}, {31'd0, we});
    chk({tag, ".pc_update"}, {31'd0, pc_update}, {31'd0, pcu});
  endtask

  // Presents word with imem_ready high in the current FETCH cycle; ends in DECODE.
  task automatic fetch(input logic [31:0] word);
    imem_rdata = word;
    imem_ready = 1'b1;
    #1;
    chk("fetch.imem_req", {31'd0, imem_req}, 32'd1);
    cyc();
    imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_branch(input logic [4:0] opc);
    logic [31:0] w;
    w = {opc, 27'h0123456};
    fetch(w);
    expect_ph("br.decode", 3'd1, 1'b0, 1'b0);
    cyc();
    expect_ph("br.execute", 3'd2, 1'b0, 1'b1);
    cyc();
    expect_ph("br.fetch", 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] w_alu, w_load, w_store, w_halt;
    w_alu   = 32'h1884_1000;
    w_load  = {5'h10, 5'd31, 5'd3, 5'd4, 12'hABC};
    w_store = {5'h13, 5'd0, 5'd5, 5'd6, 12'h001};
    w_halt  = {5'h0F, 27'd0};
    imem_rdata = 32'h0;

    // Reset state while reset is held.
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    cyc();
    expect_ph("rst", 3'd0, 1'b0, 1'b0);
    chk("rst.imem_req", {31'd0, imem_req}, 32'd1);
    chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst.instr", instr, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;

    // ALU op accepted on the first FETCH cycle: 0,1,2,4,0.
    fetch(w_alu);
    expect_ph("alu.decode", 3'd1, 1'b0, 1'b0);
    chk("alu.instr", instr, 32'h1884_1000);
    chk("alu.opcode", {27'd0, opcode}, 32'd3);
    chk("alu.read_reg1", {27'd0, read_reg1}, 32'd2);
    chk("alu.read_reg2", {27'd0, read_reg2}, 32'd1);
    chk("alu.read_reg3", {27'd0, read_reg3}, 32'd2);
    cyc();
    expect_ph("alu.execute", 3'd2, 1'b0, 1'b0);
    cyc();
    expect_ph("alu.writeback", 3'd4, 1'b1, 1'b1);
    chk("alu.write_reg", {27'd0, write_reg}, 32'd2);
    cyc();
    expect_ph("alu.fetch", 3'd0, 1'b0, 1'b0);

    // LOAD with one stalled fetch cycle and dmem_ready three cycles late; rd=31.
    #1;
    cyc();
    expect_ph("ld.fetch_wait", 3'd0, 1'b0, 1'b0);
    fetch(w_load);
    expect_ph("ld.decode", 3'd1, 1'b0, 1'b0);
    chk("ld.literal", {20'd0, literal}, 32'h0000_0ABC);
    cyc();
    expect_ph("ld.execute", 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      dmem_ready = (i == 3);
      expect_ph("ld.memory", 3'd3, 1'b0, 1'b0);
      chk("ld.dmem_req", {31'd0, dmem_req}, 32'd1);
      chk("ld.dmem_we", {31'd0, dmem_we}, 32'd0);
    end
    cyc();
    dmem_ready = 1'b0;
    expect_ph("ld.writeback", 3'd4, 1'b1, 1'b1);
    chk("ld.write_reg", {27'd0, write_reg}, 32'd31);
    chk("ld.dmem_req_wb", {31'd0, dmem_req}, 32'd0);
    cyc();
    expect_ph("ld.fetch", 3'd0, 1'b0, 1'b0);

    // STORE; imem_ready pulses outside FETCH must not change instr.
    fetch(w_store);
    imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    expect_ph("st.decode", 3'd1, 1'b0, 1'b0);
    cyc();
    expect_ph("st.execute", 3'd2, 1'b0, 1'b0);
    chk("st.instr_hold", instr, w_store);
    cyc();
    imem_ready = 1'b0;
    expect_ph("st.mem_wait", 3'd3, 1'b0, 1'b0);
    chk("st.dmem_we", {31'd0, dmem_we}, 32'd1);
    dmem_ready = 1'b1;
    expect_ph("st.mem_done", 3'd3, 1'b0, 1'b1);
    chk("st.dmem_req", {31'd0, dmem_req}, 32'd1);
    cyc();
    dmem_ready = 1'b0;
    expect_ph("st.fetch", 3'd0, 1'b0, 1'b0);
    chk("st.dmem_req_off", {31'd0, dmem_req}, 32'd0);

    // Both ends of the branch range.
    run_branch(5'h08);
    run_branch(5'h0E);

    // HALT is absorbing while ready inputs toggle.
    fetch(w_halt);
    expect_ph("halt.decode", 3'd1, 1'b0, 1'b0);
    chk("halt.halted_decode", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      imem_ready = i[0];
      dmem_ready = ~i[0];
      expect_ph("halt.hold", 3'd5, 1'b0, 1'b0);
      chk("halt.halted", {31'd0, halted}, 32'd1);
      chk("halt.reqs", {30'd0, imem_req, dmem_req}, 32'd0);
    end
    chk("halt.fault", {31'd0, fault}, 32'd0);
    chk("halt.instr", instr, w_halt);

    // Reset out of HALT, then an asynchronous reset while waiting in MEMORY.
    do_reset();
    chk("rst2.halted", {31'd0, halted}, 32'd0);
    fetch(w_load);
    cyc();
    cyc();
    #1;
    chk("amr.dmem_req", {31'd0, dmem_req}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("amr.state", {29'd0, state}, 32'd0);
    chk("amr.dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("amr.instr", instr, 32'd0);
    chk("amr.halted", {31'd0, halted}, 32'd0);
    chk("amr.imem_req", {31'd0, imem_req}, 32'd1);
    cyc();
    reset = 1'b0;
    fetch(w_alu);
    expect_ph("amr.refetch", 3'd1, 1'b0, 1'b0);
    chk("amr.refetch_instr", instr, w_alu);

    // Fetch timeout: four low cycles in FETCH, then HALT with fault.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      expect_ph("to.wait", 3'd0, 1'b0, 1'b0);
      chk("to.fault_wait", {31'd0, fault}, 32'd0);
      cyc();
    end
    expect_ph("to.halt", 3'd5, 1'b0, 1'b0);
    chk("to.fault", {31'd0, fault}, 32'd1);
    chk("to.halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 6; i++) cyc();
    chk("to0.state", {29'd0, state0}, 32'd0);
    chk("to0.fault", {31'd0, fault0}, 32'd0);
    chk("to0.imem_req", {31'd0, imem_req0}, 32'd1);

    // Ready arriving in the limit cycle wins.
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    fetch(w_alu);
    expect_ph("tor.decode", 3'd1, 1'b0, 1'b0);
    chk("tor.fault", {31'd0, fault}, 32'd0);
    chk("tor.instr", instr, w_alu);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
